// File: rtl/gpu_fb_scanout.sv
// Framebuffer scanout engine: issues raster-order SRAM reads, tracks them through a
// fixed-latency read pipeline and buffers the returned pixels in a fall-through FIFO.
module gpu_fb_scanout #(
    parameter int unsigned WIDTH_BITS   = 10,
    parameter int unsigned HEIGHT_BITS  = 9,
    parameter int unsigned CHANNEL_BITS = 8,
    parameter int unsigned H_RES        = 640,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned RD_LAT       = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable_i,
    input  logic                                  fb_sel_i,
    input  logic                                  mem_grant_i,
    input  logic [3*CHANNEL_BITS-1:0]             rgbdata_i,
    output logic                                  CE0_o,
    output logic                                  CE1_o,
    output logic                                  R_W_o,
    output logic                                  OE_o,
    output logic                                  LB_o,
    output logic                                  UB_o,
    output logic                                  ZZ_o,
    output logic                                  SEM_o,
    output logic [WIDTH_BITS+HEIGHT_BITS:0]       adddata_o,
    output logic                                  pix_valid_o,
    input  logic                                  pix_ready_i,
    output logic [3*CHANNEL_BITS-1:0]             pix_rgb_o,
    output logic [WIDTH_BITS-1:0]                 pix_x_o,
    output logic [HEIGHT_BITS-1:0]                pix_y_o,
    output logic                                  sof_o,
    output logic                                  eol_o,
    output logic                                  frame_done_o,
    output logic                                  busy_o
);

    localparam int unsigned ADDR_W = WIDTH_BITS + HEIGHT_BITS + 1;
    localparam int unsigned RGB_W  = 3 * CHANNEL_BITS;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LAT_W  = $clog2(RD_LAT + 1);
    localparam int unsigned SUM_W  = CNT_W + LAT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    logic                    fb_sel_q;
    logic [WIDTH_BITS-1:0]   x_q;
    logic [HEIGHT_BITS-1:0]  y_q;
    logic [ADDR_W-1:0]       addr_q;

    logic [RD_LAT-1:0]       pipe_valid;
    logic [WIDTH_BITS-1:0]   pipe_x [RD_LAT];
    logic [HEIGHT_BITS-1:0]  pipe_y [RD_LAT];
    logic [LAT_W-1:0]        inflight;

    logic [RGB_W-1:0]        fifo_rgb [FIFO_DEPTH];
    logic [WIDTH_BITS-1:0]   fifo_x   [FIFO_DEPTH];
    logic [HEIGHT_BITS-1:0]  fifo_y   [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;

    logic issue;
    logic push;
    logic pop;
    logic last_x;
    logic last_y;
    logic drained;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + LAT_W'(pipe_valid[i]);
        end
    end

    // Reads already issued but not yet popped reserve FIFO space, so a push never finds it full.
    assign issue   = (state == FETCH) && mem_grant_i &&
                     ((SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH));
    assign push    = pipe_valid[RD_LAT-1];
    assign pop     = pix_valid_o && pix_ready_i;
    assign last_x  = (x_q == WIDTH_BITS'(H_RES - 1));
    assign last_y  = (y_q == HEIGHT_BITS'(V_RES - 1));
    assign drained = (inflight == '0) && (count == '0);

    // SRAM strobes follow the grant within the same cycle; the address holds between reads.
    assign CE0_o     = !issue;
    assign CE1_o     = issue;
    assign OE_o      = !issue;
    assign R_W_o     = 1'b1;
    assign LB_o      = !issue;
    assign UB_o      = !issue;
    assign ZZ_o      = 1'b0;
    assign SEM_o     = 1'b1;
    assign adddata_o = issue ? {fb_sel_q, y_q, x_q} : addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            fb_sel_q     <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (issue) begin
                addr_q <= {fb_sel_q, y_q, x_q};
            end
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        fb_sel_q <= fb_sel_i;
                        x_q      <= '0;
                        y_q      <= '0;
                        state    <= FETCH;
                        busy_o   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        if (last_x) begin
                            x_q <= '0;
                            if (last_y) begin
                                y_q   <= '0;
                                state <= DRAIN;
                            end else begin
                                y_q <= y_q + HEIGHT_BITS'(1);
                            end
                        end else begin
                            x_q <= x_q + WIDTH_BITS'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        frame_done_o <= 1'b1;
                        if (enable_i) begin
                            fb_sel_q <= fb_sel_i;
                            x_q      <= '0;
                            y_q      <= '0;
                            state    <= FETCH;
                        end else begin
                            state    <= IDLE;
                            busy_o   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Coordinates of each outstanding read travel alongside it until its data returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_x[i] <= '0;
                pipe_y[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_x[0]     <= x_q;
            pipe_y[0]     <= y_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_x[i]     <= pipe_x[i-1];
                pipe_y[i]     <= pipe_y[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rgb[wr_ptr] <= rgbdata_i;
            fifo_x[wr_ptr]   <= pipe_x[RD_LAT-1];
            fifo_y[wr_ptr]   <= pipe_y[RD_LAT-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Payload is forced to zero when empty so no stale entry is ever visible.
    assign pix_valid_o = (count != '0);
    assign pix_rgb_o   = pix_valid_o ? fifo_rgb[rd_ptr] : '0;
    assign pix_x_o     = pix_valid_o ? fifo_x[rd_ptr]   : '0;
    assign pix_y_o     = pix_valid_o ? fifo_y[rd_ptr]   : '0;
    assign sof_o       = pix_valid_o && (pix_x_o == '0) && (pix_y_o == '0);
    assign eol_o       = pix_valid_o && (pix_x_o == WIDTH_BITS'(H_RES - 1));

endmodule

// File: tb/tb_gpu_fb_scanout.sv
// Randomized bench for gpu_fb_scanout on a 4x2 frame: a raster-order pixel list per frame
// is the reference for both the SRAM address sequence and the output pixel stream.
module tb_gpu_fb_scanout;

    localparam int unsigned WB    = 10;
    localparam int unsigned HB    = 9;
    localparam int unsigned CB    = 8;
    localparam int unsigned H     = 4;
    localparam int unsigned V     = 2;
    localparam int unsigned RL    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int          NPIX  = H * V;

    localparam int M_ALWAYS = 0;
    localparam int M_RANDOM = 1;
    localparam int M_TOGGLE = 2;
    localparam int M_NEVER  = 3;

    typedef struct packed {
        logic          fb;
        logic [HB-1:0] y;
        logic [WB-1:0] x;
    } pix_t;

    typedef struct {
        pix_t p;
        int   frame;
        int   idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic enable_i;
    logic fb_sel_i;
    logic mem_grant_i;
    logic pix_ready_i;
    logic [3*CB-1:0] rgbdata_i;
    logic CE0_o, CE1_o, R_W_o, OE_o, LB_o, UB_o, ZZ_o, SEM_o;
    logic [WB+HB:0] adddata_o;
    logic pix_valid_o;
    logic [3*CB-1:0] pix_rgb_o;
    logic [WB-1:0] pix_x_o;
    logic [HB-1:0] pix_y_o;
    logic sof_o, eol_o, frame_done_o, busy_o;

    exp_t iss_q[$];
    exp_t pix_q[$];
    bit   frame_fb[$];
    int   errors, checks, cyc;
    int   issued, popped, max_out, frames_delivered, done_count, stop_frame;
    int   grant_mode, ready_mode;
    pix_t last_addr;
    logic prev_done;
    logic [3*CB-1:0] sram_in;
    logic [3*CB-1:0] sram_q [RL];

    always #5 clk = ~clk;

    // SRAM model: data word equals the address presented RL cycles earlier.
    always @(posedge clk) begin
        sram_q[0] <= sram_in;
        for (int i = 1; i < RL; i++) sram_q[i] <= sram_q[i-1];
    end
    assign rgbdata_i = sram_q[RL-1];

    gpu_fb_scanout #(
        .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB),
        .H_RES(H), .V_RES(V), .RD_LAT(RL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .fb_sel_i(fb_sel_i),
        .mem_grant_i(mem_grant_i), .rgbdata_i(rgbdata_i),
        .CE0_o(CE0_o), .CE1_o(CE1_o), .R_W_o(R_W_o), .OE_o(OE_o),
        .LB_o(LB_o), .UB_o(UB_o), .ZZ_o(ZZ_o), .SEM_o(SEM_o),
        .adddata_o(adddata_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
        .pix_rgb_o(pix_rgb_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
        .sof_o(sof_o), .eol_o(eol_o), .frame_done_o(frame_done_o), .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        iss_q.delete();
        pix_q.delete();
        frame_fb.delete();
        issued           = 0;
        popped           = 0;
        frames_delivered = 0;
        done_count       = 0;
        last_addr        = '0;
        prev_done        = 1'b0;
    endtask

    task automatic add_frame(input bit fb);
        exp_t e;
        int   f;
        f = frame_fb.size();
        frame_fb.push_back(fb);
        for (int y = 0; y < int'(V); y++) begin
            for (int x = 0; x < int'(H); x++) begin
                e.p.fb  = fb;
                e.p.y   = HB'(y);
                e.p.x   = WB'(x);
                e.frame = f;
                e.idx   = y * int'(H) + x;
                iss_q.push_back(e);
                pix_q.push_back(e);
            end
        end
    endtask

    task automatic reset_check();
        check("rst_ctl", 64'({CE0_o, CE1_o, R_W_o, OE_o, LB_o, UB_o, ZZ_o, SEM_o,
                              adddata_o, frame_done_o, busy_o}),
                         64'({8'hBD, 20'h0, 2'b00}));
        check("rst_pix", 64'({pix_valid_o, pix_rgb_o, pix_x_o, pix_y_o, sof_o, eol_o}), 64'd0);
    endtask

    // Observes one cycle's outputs against the reference and advances it.
    task automatic monitor();
        logic [7:0]  ctrl;
        logic [63:0] exp_pix;
        exp_t        e;
        ctrl    = {CE0_o, CE1_o, R_W_o, OE_o, LB_o, UB_o, ZZ_o, SEM_o};
        sram_in = 24'hF00000 | 24'($urandom_range(0, 20'hFFFFF));
        if (!CE0_o) begin
            sram_in = 24'(adddata_o);
            check("ctrl_issue", 64'(ctrl), 64'h61);
            check("issue_grant", 64'(mem_grant_i), 64'd1);
            check("issue_room", 64'((issued - popped) < int'(DEPTH)), 64'd1);
            issued++;
            if (issued - popped > max_out) max_out = issued - popped;
            if (iss_q.size() == 0) begin
                check("issue_extra", 64'(!CE0_o), 64'd0);
            end else begin
                e = iss_q.pop_front();
                check("issue_addr", 64'(adddata_o), 64'(e.p));
                last_addr = e.p;
                if (e.idx == 1) fb_sel_i = ~frame_fb[e.frame];
                if (e.idx == 5) fb_sel_i = (e.frame + 1 < frame_fb.size()) ? frame_fb[e.frame+1] : 1'b0;
                if (e.idx == 3 && e.frame == stop_frame) enable_i = 1'b0;
            end
        end else begin
            check("ctrl_idle", 64'(ctrl), 64'hBD);
            check("addr_hold", 64'(adddata_o), 64'(last_addr));
        end
        if (pix_valid_o) begin
            if (pix_q.size() == 0) begin
                check("pix_extra", 64'(pix_valid_o), 64'd0);
            end else begin
                e = pix_q[0];
                exp_pix = 64'({24'(e.p), e.p.x, e.p.y,
                               (e.p.x == '0) && (e.p.y == '0), e.p.x == WB'(H - 1)});
                check("pix", 64'({pix_rgb_o, pix_x_o, pix_y_o, sof_o, eol_o}), exp_pix);
                if (pix_ready_i) begin
                    void'(pix_q.pop_front());
                    popped++;
                    if (e.idx == NPIX - 1) frames_delivered++;
                end
            end
        end else begin
            check("flags_idle", 64'({sof_o, eol_o}), 64'd0);
        end
        if (frame_done_o) begin
            check("done_seq", 64'(frames_delivered), 64'(done_count + 1));
            check("done_width", 64'(prev_done), 64'd0);
            done_count++;
        end
        prev_done = frame_done_o;
        if (issued != popped) check("busy", 64'(busy_o), 64'd1);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        case (grant_mode)
            M_ALWAYS: mem_grant_i = 1'b1;
            M_RANDOM: mem_grant_i = 1'($urandom_range(0, 1));
            M_TOGGLE: mem_grant_i = 1'(cyc % 2);
            default:  mem_grant_i = 1'b0;
        endcase
        case (ready_mode)
            M_ALWAYS: pix_ready_i = 1'b1;
            M_RANDOM: pix_ready_i = 1'($urandom_range(0, 1));
            M_TOGGLE: pix_ready_i = 1'(cyc % 2);
            default:  pix_ready_i = 1'b0;
        endcase
        #1;
        monitor();
    endtask

    task automatic start_frames(input int n, input bit first_fb, input bit rand_fb);
        bit fb;
        fb = first_fb;
        for (int i = 0; i < n; i++) begin
            if (i > 0) fb = rand_fb ? 1'($urandom_range(0, 1)) : ~fb;
            add_frame(fb);
        end
        stop_frame = frame_fb.size() - 1;
        fb_sel_i   = first_fb;
        enable_i   = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(iss_q.size() == 0 && pix_q.size() == 0 &&
                 done_count == int'(frame_fb.size()) && !busy_o) && n < budget) begin
            step();
            n++;
        end
        check("idle_reached", 64'(n < budget), 64'd1);
        check("frames_done", 64'(done_count), 64'(frame_fb.size()));
        repeat (4) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        errors = 0; checks = 0; cyc = 0; max_out = 0; stop_frame = -1;
        rst = 1'b1; enable_i = 1'b0; fb_sel_i = 1'b0;
        mem_grant_i = 1'b0; pix_ready_i = 1'b0; sram_in = '0;
        grant_mode = M_ALWAYS; ready_mode = M_ALWAYS;
        model_clear();
        repeat (3) step();
        reset_check();
        rst = 1'b0;
        repeat (3) step();

        // Plain frame, full grant and ready.
        start_frames(1, 1'b0, 1'b0);
        wait_idle(200);

        // Sink stalled: only FIFO_DEPTH reads may go out.
        ready_mode = M_NEVER;
        base = issued;
        start_frames(1, 1'b1, 1'b0);
        repeat (20) step();
        check("stall_issues", 64'(issued - base), 64'(DEPTH));
        ready_mode = M_ALWAYS;
        wait_idle(200);

        // Grant on alternate cycles.
        grant_mode = M_TOGGLE;
        start_frames(1, 1'b0, 1'b0);
        wait_idle(300);
        grant_mode = M_ALWAYS;

        // Back-to-back frames, fb_sel flipped mid-frame.
        start_frames(2, 1'b1, 1'b0);
        wait_idle(400);

        // Random grant/ready with random framebuffer choice per frame.
        grant_mode = M_RANDOM;
        ready_mode = M_RANDOM;
        repeat (4) begin
            start_frames(5, 1'($urandom_range(0, 1)), 1'b1);
            wait_idle(3000);
        end
        grant_mode = M_ALWAYS;
        ready_mode = M_ALWAYS;

        // Reset with reads outstanding, then a fresh frame.
        ready_mode = M_NEVER;
        base = issued;
        start_frames(1, 1'b1, 1'b0);
        n = 0;
        while (issued - base < 3 && n < 50) begin
            step();
            n++;
        end
        check("pre_rst_issues", 64'(issued - base), 64'd3);
        step();
        rst = 1'b1;
        #1;
        reset_check();
        enable_i = 1'b0;
        model_clear();
        repeat (2) step();
        reset_check();
        rst = 1'b0;
        ready_mode = M_ALWAYS;
        repeat (4) step();
        start_frames(1, 1'b0, 1'b0);
        wait_idle(200);

        check("fifo_bound", 64'(max_out), 64'(DEPTH));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
